// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared constants and status type for the UART FIFO controller
package uart_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_AF_LEVEL   = 12;
    localparam int DEF_AE_LEVEL   = 2;

    // Snapshot of all status flags, used by monitors and scoreboards.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap counter with increment enable and synchronous clear
module fifo_ptr
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    // Clear wins over increment; the counter wraps naturally at 2**WIDTH.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - UART FIFO pointer/status controller (optional level output: UART_FIFO_LEVEL_EN)
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = DEF_AF_LEVEL,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef UART_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_L = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] occupancy;
    logic                push_ok;
    logic                pop_ok;
    logic                ovf_evt;
    logic                udf_evt;
    logic                overflow_q;
    logic                overflow_d;
    logic                underflow_q;
    logic                underflow_d;

    fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (push_ok),
        .ptr   (wptr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (pop_ok),
        .ptr   (rptr)
    );

    // Occupancy and flags straight from the registered pointers.
    always_comb begin
        occupancy    = wptr - rptr;
        empty        = (wptr == rptr);
        full         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                       (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
        almost_full  = (occupancy >= AF_L);
        almost_empty = (occupancy <= AE_L);
    end

    // Accept/reject decisions; a pop while full frees the slot the push lands in.
    always_comb begin
        push_ok = !flush && wr && (!full || rd);
        pop_ok  = !flush && rd && !empty;
        ovf_evt = !flush && wr && full && !rd;
        udf_evt = !flush && rd && empty;
        w_en    = push_ok;
    end

    // Sticky error next state: flush clears, a new error beats clr_err.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow_d = 1'b1;
            end else if (clr_err) begin
                overflow_d = 1'b0;
            end
            if (udf_evt) begin
                underflow_d = 1'b1;
            end else if (clr_err) begin
                underflow_d = 1'b0;
            end
        end
    end

    // Sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign w_addr    = wptr[ADDR_WIDTH-1:0];
    assign r_addr    = rptr[ADDR_WIDTH-1:0];

`ifdef UART_FIFO_LEVEL_EN
    logic [ADDR_WIDTH:0] level_q;
    logic [ADDR_WIDTH:0] level_d;

    // Level tracks the post-edge occupancy so it updates with the pointers.
    always_comb begin
        level_d = occupancy + (ADDR_WIDTH + 1)'(push_ok) - (ADDR_WIDTH + 1)'(pop_ok);
        if (flush) begin
            level_d = '0;
        end
    end

    // Registered level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Pointer and status controller for the UART TX/RX FIFOs. It is the access-control end of the FIFO storage array.
- Converts push/pop requests from the UART datapath into the storage write enable and write/read addresses.
- Tracks occupancy and produces full, empty, almost-full and almost-empty flags, plus sticky overflow/underflow error flags.
- Storage itself is external (register-file array, combinational read, write on clock edge); this block holds no data.

Parameters:
- ADDR_WIDTH, 4, address bits into the storage; depth DEPTH = 2**ADDR_WIDTH entries (legal 1..8).
- AF_LEVEL, 12, almost_full asserts when occupancy >= AF_LEVEL (legal 1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when occupancy <= AE_LEVEL (legal 0..DEPTH-1).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- wr  in  1  push request from producer (one word per cycle)
- rd  in  1  pop request from consumer (one word per cycle)
- flush  in  1  synchronous clear of pointers and error flags
- clr_err  in  1  synchronous clear of overflow/underflow only
- w_en  out  1  storage write enable (combinational)
- w_addr  out  ADDR_WIDTH  storage write address (registered pointer)
- r_addr  out  ADDR_WIDTH  storage read address (registered pointer); storage data at r_addr is the head word
- full  out  1  no free entry
- empty  out  1  no valid entry
- almost_full  out  1  occupancy >= AF_LEVEL
- almost_empty  out  1  occupancy <= AE_LEVEL
- overflow  out  1  sticky: push rejected since last clear
- underflow  out  1  sticky: pop rejected since last clear

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits each.
  - w_addr/r_addr are the low ADDR_WIDTH bits.
  - MSB toggles on each wrap-around.
- Occupancy and flags (all combinational from registered pointers, no extra latency):
  - occupancy = wptr - rptr, modulo 2**(ADDR_WIDTH+1), range 0..DEPTH.
  - empty = (wptr == rptr).
  - full = (MSBs differ and low bits equal).
- Reset values:
  - wptr = rptr = 0, overflow = underflow = 0.
  - Hence w_addr = r_addr = 0, empty = 1, full = 0, almost_empty = 1.
  - almost_full = 0 unless AF_LEVEL = 0 (illegal).
  - w_en = 0 while wr = 0.
- Push accepted when wr && (!full || rd):
  - w_en = 1 in that same cycle.
  - wptr increments at the next edge.
  - The written word is readable at r_addr the cycle after the write edge.
- Pop accepted when rd && !empty; rptr increments at the next edge.
  - The consumer samples the head word combinationally in the cycle rd is high.
- Simultaneous events:
  - wr && rd while full: both accepted. Head is read before the edge; the new word lands in the freed slot. full stays 1.
  - wr && rd while empty: push accepted, pop rejected, underflow set. Next cycle: empty = 0, occupancy 1.
  - wr && rd otherwise: both accepted, occupancy unchanged.
- Rejections:
  - wr while full without rd: w_en = 0, wptr held, overflow set at the next edge.
  - rd while empty: rptr held, underflow set at the next edge.
- Wrap-around: the low address rolls DEPTH-1 -> 0; the MSB toggles; no stall.
- flush:
  - Has priority over wr/rd that cycle.
  - w_en is forced 0 while flush = 1.
  - Next edge: wptr = rptr = 0, overflow = underflow = 0.
- clr_err:
  - Clears the sticky flags at the next edge.
  - If a new error occurs in the same cycle, the error wins (flag = 1).
- Reset asserted mid-operation: immediately returns all state to reset values, regardless of clk. Storage contents are not cleared.
- No state machine beyond pointer registers. Sticky flags are two 1-bit registers.

Optional Feature:
- Macro: UART_FIFO_LEVEL_EN.
- Defined:
  - Adds output port level, width ADDR_WIDTH+1, equal to occupancy.
  - level is registered: updated at the same edge as the pointers and equal to wptr - rptr after that edge.
  - level reset value is 0.
- Undefined: port absent, no extra registers.
- Flags behave identically in both builds.

Decomposition:
- Shared package uart_fifo_pkg:
  - DEF_ADDR_WIDTH, DEF_AF_LEVEL and DEF_AE_LEVEL constants.
  - Typedef fifo_status_t: packed struct {full, empty, almost_full, almost_empty, overflow, underflow} for monitor/scoreboard use.
- Optional sub-module fifo_ptr: an (ADDR_WIDTH+1)-bit wrap counter with increment enable and synchronous clear, instanced once for wptr and once for rptr.
- Flag logic stays in the top.

Test Plan:
- Reset:
  - Assert reset mid-burst, asynchronously between edges.
  - Required: outputs reach reset values immediately (empty = 1, full = 0, addresses 0, errors 0).
- Fill and drain with DEPTH = 16:
  - 16 pushes -> full = 1 after the 16th edge and almost_full = 1 from occupancy 12.
  - 16 pops -> empty = 1, r_addr = 0, and almost_empty = 1 at occupancy 2.
- Overflow:
  - Push a 17th word when full.
  - Required: w_en = 0, w_addr unchanged, overflow = 1 and sticky.
  - Then clr_err -> overflow = 0.
- Underflow on empty with wr = rd = 1:
  - Required: w_en = 1, empty = 0 next cycle, occupancy 1, underflow = 1.
- Full with wr = rd = 1 for 20 cycles:
  - Required: full stays 1, both addresses advance and wrap 15 -> 0, no overflow.
- Flush:
  - Occupancy 7 with overflow set; assert flush together with wr = 1.
  - Required: w_en = 0, next cycle empty = 1, pointers 0, overflow = 0.
  - With UART_FIFO_LEVEL_EN: level reads 7, then 0.
